// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: default divisor width and
// the square-wave mode encoding carried alongside each divisor.
package clk_div_pkg;

    localparam int DIV_W_DEF = 8;

    localparam logic SQ_OFF = 1'b0;
    localparam logic SQ_ON  = 1'b1;

endpackage

// File: rtl/clock_divider_bank_if.sv
// Register-write port of the divider bank. The host (master) presents one
// write per cycle; wr is a plain strobe, the bank always accepts it.
interface clock_divider_bank_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            wr;
    logic [CH_W-1:0] wr_ch;
    logic [DIV_W-1:0] wr_div;
    logic            wr_sq;
    logic            wr_force;

    modport master (output wr, wr_ch, wr_div, wr_sq, wr_force);
    modport slave  (input  wr, wr_ch, wr_div, wr_sq, wr_force);

endinterface

// File: rtl/clock_divider_ch.sv
// One divider channel: counter 0..act, shadow divisor applied at the wrap
// cycle (or at once when forced), registered tick and square outputs.
module clock_divider_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_sq,
    input  logic             wr_force,
    output logic             tick,
    output logic             sq,
    output logic             pending,
    output logic [DIV_W-1:0] act_div
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] shd_div;
    logic             sqm;
    logic             shd_sq;
    logic             wrap;
    logic [DIV_W:0]   half;
    logic             in_high;

    // One extra bit so act = all-ones still yields a half period of 2^(DIV_W-1).
    assign wrap    = (cnt == act);
    assign half    = ({1'b0, act} + (DIV_W+1)'(2)) >> 1;
    assign in_high = ({1'b0, cnt} < half);
    assign act_div = act;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            act     <= '0;
            sqm     <= SQ_OFF;
            shd_div <= '0;
            shd_sq  <= SQ_OFF;
            pending <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
        end else if (wr_en && wr_force) begin
            // Truncated period: restart silently, drop any staged value.
            cnt     <= '0;
            act     <= wr_div;
            sqm     <= wr_sq;
            shd_div <= wr_div;
            shd_sq  <= wr_sq;
            pending <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
        end else begin
            tick <= wrap;
            sq   <= (sqm == SQ_ON) && in_high;
            if (wrap) begin
                cnt     <= '0;
                pending <= 1'b0;
                if (wr_en) begin
                    // Write landing on the boundary bypasses the shadow.
                    act     <= wr_div;
                    sqm     <= wr_sq;
                    shd_div <= wr_div;
                    shd_sq  <= wr_sq;
                end else if (pending) begin
                    act <= shd_div;
                    sqm <= shd_sq;
                end
            end else begin
                cnt <= cnt + DIV_W'(1);
                if (wr_en) begin
                    shd_div <= wr_div;
                    shd_sq  <= wr_sq;
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent programmable dividers sharing one write port;
// decodes the channel select and flattens the per-channel outputs.
module clock_divider_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    clock_divider_bank_if.slave     bus,
    output logic [NUM_CH-1:0]       tick_out,
    output logic [NUM_CH-1:0]       sq_out,
    output logic [NUM_CH-1:0]       pending,
    output logic [NUM_CH*DIV_W-1:0] div_active
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] wr_en;

    // Selects beyond NUM_CH-1 match no channel, so such writes are dropped.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_en[i] = bus.wr && (bus.wr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_divider_ch #(.DIV_W(DIV_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[g]),
            .wr_div   (bus.wr_div),
            .wr_sq    (bus.wr_sq),
            .wr_force (bus.wr_force),
            .tick     (tick_out[g]),
            .sq       (sq_out[g]),
            .pending  (pending[g]),
            .act_div  (div_active[g*DIV_W +: DIV_W])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: directed scenarios plus random writes, all
// checked every cycle against a period/phase model of each channel.
module tb_clock_divider_bank;
  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       tick_out;
  logic [NUM_CH-1:0]       sq_out;
  logic [NUM_CH-1:0]       pending;
  logic [NUM_CH*DIV_W-1:0] div_active;

  clock_divider_bank_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clock_divider_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .tick_out   (tick_out),
    .sq_out     (sq_out),
    .pending    (pending),
    .div_active (div_active)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: each channel is a period P, a phase within it, a mode, and an
  // optional staged (period, mode) that takes over when the period ends
  int m_ph[NUM_CH];
  int m_per[NUM_CH];
  bit m_mode[NUM_CH];
  bit m_stg[NUM_CH];
  int m_stg_per[NUM_CH];
  bit m_stg_mode[NUM_CH];
  bit m_tick[NUM_CH];
  bit m_sq[NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_ph[i] = 0; m_per[i] = 1; m_mode[i] = 0; m_stg[i] = 0;
        m_stg_per[i] = 1; m_stg_mode[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        bit last;
        bit hit;
        last = (m_ph[i] == m_per[i] - 1);
        hit  = bus.wr && (int'(bus.wr_ch) == i);
        if (hit && bus.wr_force) begin
          m_per[i] = int'(bus.wr_div) + 1; m_mode[i] = bus.wr_sq;
          m_ph[i] = 0; m_stg[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
        end else begin
          m_tick[i] = last;
          m_sq[i]   = m_mode[i] && (m_ph[i] < (m_per[i] + 1) / 2);
          if (last) begin
            if (hit) begin
              m_per[i] = int'(bus.wr_div) + 1; m_mode[i] = bus.wr_sq;
            end else if (m_stg[i]) begin
              m_per[i] = m_stg_per[i]; m_mode[i] = m_stg_mode[i];
            end
            m_stg[i] = 0;
            m_ph[i]  = 0;
          end else begin
            m_ph[i]++;
            if (hit) begin
              m_stg[i] = 1; m_stg_per[i] = int'(bus.wr_div) + 1; m_stg_mode[i] = bus.wr_sq;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("tick[%0d]", i), 32'(tick_out[i]), 32'(m_tick[i]));
      check($sformatf("sq[%0d]", i), 32'(sq_out[i]), 32'(m_sq[i]));
      check($sformatf("pending[%0d]", i), 32'(pending[i]), 32'(m_stg[i]));
      check($sformatf("div_active[%0d]", i), 32'(div_active[i*DIV_W +: DIV_W]),
            32'(m_per[i] - 1));
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    bus.wr       = 1'b0;
    bus.wr_force = 1'b0;
  endtask

  task automatic write(input int ch, input int dv, input bit sqv, input bit frc);
    bus.wr       = 1'b1;
    bus.wr_ch    = 2'(ch);
    bus.wr_div   = DIV_W'(dv);
    bus.wr_sq    = sqv;
    bus.wr_force = frc;
    step();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // advance until the channel's model phase equals ph (bounded)
  task automatic wait_phase(input int ch, input int ph);
    int budget;
    budget = 600;
    while (m_ph[ch] != ph && budget > 0) begin
      step();
      budget--;
    end
    check($sformatf("wait_phase[%0d]", ch), 32'(m_ph[ch]), 32'(ph));
  endtask

  initial begin
    int cnt_t;
    int cnt_s;
    int exp_pend;
    rst = 1'b1;
    bus.wr = 1'b0; bus.wr_ch = '0; bus.wr_div = '0; bus.wr_sq = 1'b0; bus.wr_force = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_ph[i] = 0; m_per[i] = 1; m_mode[i] = 0; m_stg[i] = 0;
      m_stg_per[i] = 1; m_stg_mode[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
    end

    // reset and release
    run(2);
    check("rst_tick", 32'(tick_out), 32'h0);
    check("rst_div", 32'(div_active), 32'h0);
    rst = 1'b0;
    step();
    check("rel_tick", 32'(tick_out), 32'h7);
    check("rel_sq", 32'(sq_out), 32'h0);
    check("rel_pend", 32'(pending), 32'h0);
    run(3);

    // ch1: divisor 4, square on, written while act=0
    write(1, 4, 1'b1, 1'b0);
    cnt_t = 0; cnt_s = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      cnt_t += int'(tick_out[1]);
      cnt_s += int'(sq_out[1]);
    end
    check("ch1_ticks20", 32'(cnt_t), 32'd4);
    check("ch1_sqhigh20", 32'(cnt_s), 32'd12);

    // ch2: run at act=9, stage 2 at cnt=3
    write(2, 9, 1'b1, 1'b1);
    run(4);
    wait_phase(2, 3);
    exp_pend = 9 - 3;
    write(2, 2, 1'b1, 1'b0);
    cnt_t = int'(pending[2]);
    for (int k = 0; k < 14; k++) begin
      step();
      cnt_t += int'(pending[2]);
    end
    check("ch2_pend_len", 32'(cnt_t), 32'(exp_pend));
    check("ch2_newdiv", 32'(div_active[2*DIV_W +: DIV_W]), 32'd2);

    // ch0: act=7, stage 5, then force 1 at cnt=5
    write(0, 7, 1'b1, 1'b1);
    run(3);
    write(0, 5, 1'b0, 1'b0);
    wait_phase(0, 5);
    write(0, 1, 1'b1, 1'b1);
    check("ch0_force_pend", 32'(pending[0]), 32'h0);
    check("ch0_force_tick", 32'(tick_out[0]), 32'h0);
    cnt_t = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      cnt_t += int'(tick_out[0]);
    end
    check("ch0_ticks10", 32'(cnt_t), 32'd5);

    // write on ch2's own wrap cycle
    wait_phase(2, m_per[2] - 1);
    write(2, 6, 1'b0, 1'b0);
    check("ch2_bypass_pend", 32'(pending[2]), 32'h0);
    check("ch2_bypass_div", 32'(div_active[2*DIV_W +: DIV_W]), 32'd6);
    run(5);

    // out-of-range channel select
    write(NUM_CH, 33, 1'b1, 1'b1);
    write(NUM_CH, 44, 1'b1, 1'b0);
    run(4);

    // full-range divisor: 256-cycle period, 128/128 duty
    write(1, 255, 1'b1, 1'b1);
    cnt_t = 0; cnt_s = 0;
    for (int k = 0; k < 512; k++) begin
      step();
      cnt_t += int'(tick_out[1]);
      cnt_s += int'(sq_out[1]);
    end
    check("ch1_ticks512", 32'(cnt_t), 32'd2);
    check("ch1_sqhigh512", 32'(cnt_s), 32'd256);

    // random writes with small divisors
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0)
        write(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      else
        step();
    end

    // reset mid-period with a staged write outstanding
    write(1, 3, 1'b1, 1'b0);
    run(2);
    rst = 1'b1;
    step();
    check("mid_rst_tick", 32'(tick_out), 32'h0);
    check("mid_rst_sq", 32'(sq_out), 32'h0);
    check("mid_rst_pend", 32'(pending), 32'h0);
    check("mid_rst_div", 32'(div_active), 32'h0);
    rst = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
